// File: rtl/microcode_exec_pkg.sv
// microcode_pkg: control-word codes and FSM states shared by the sequencer and its control-word memory.
package microcode_pkg;
    localparam logic [2:0] LOADX = 3'b000;
    localparam logic [2:0] LOADY = 3'b001;
    localparam logic [2:0] ADD   = 3'b010;
    localparam logic [2:0] SHIFT = 3'b011;
    localparam logic [2:0] LOADZ = 3'b100;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/microcode_exec_if.sv
// microcode_exec_if: start/status handshake plus step-index / control-word memory port.
interface microcode_exec_if #(parameter int W = 8);
    logic         start;
    logic [2:0]   count;
    logic [2:0]   ctrl;
    logic [W-1:0] val;
    logic         busy;
    logic         done;
    logic         err;
    logic [2*W-1:0] result;
    modport master (output start, ctrl, val, input count, busy, done, err, result);
    modport slave  (input start, ctrl, val, output count, busy, done, err, result);
endinterface

// File: rtl/microcode_exec_shift_add_datapath.sv
// shift_add_datapath: X/Y/Z registers of the shift-and-add multiplier, driven by the current control word.
module shift_add_datapath import microcode_pkg::*; #(parameter int W = 8) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [2:0]     op,
    input  logic [W-1:0]   val,
    output logic [2*W-1:0] z
);
    logic [2*W-1:0] x;
    logic [W-1:0]   y;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x <= '0;
            y <= '0;
            z <= '0;
        end else if (en) begin
            x <= op == LOADX ? {{W{1'b0}}, val} : op == SHIFT ? x << 1 : op == LOADZ ? '0 : x;
            y <= (op == LOADX || op == LOADZ) ? '0 : op == LOADY ? val : op == SHIFT ? y >> 1 : y;
            z <= op == LOADX ? '0 : (op == ADD && y[0]) ? z + x : z;
        end
endmodule

// File: rtl/microcode_exec.sv
// microcode_exec: steps a control-word memory through a shift-and-add multiply; the start edge executes step 0.
module microcode_exec import microcode_pkg::*; #(
    parameter int         W         = 8,
    parameter logic [2:0] LAST_STEP = 3'b100
) (
    input logic               clk,
    input logic               rst_n,
    microcode_exec_if.slave   bus
);
    localparam int IW = $clog2(W) + 1;
    localparam logic [IW-1:0] I_LAST = IW'(W - 1);
    state_e         state;
    logic [IW-1:0]  i;
    logic [2*W-1:0] z;
    logic           exec, illegal, fin;
    logic [2:0]     nxt;
    always_comb begin
        exec    = state == RUN || bus.start;
        illegal = bus.ctrl > LOADZ;
        fin     = bus.ctrl == LOADZ || illegal;
        nxt     = bus.ctrl == LOADX ? 3'b001 :
                  bus.ctrl == LOADY ? 3'b010 :
                  bus.ctrl == ADD   ? 3'b011 :
                  bus.ctrl == SHIFT ? (i < I_LAST ? 3'b010 : LAST_STEP) : 3'b000;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            i          <= '0;
            bus.count  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= exec && bus.ctrl == LOADZ;
            bus.err  <= exec && illegal;
            if (exec) begin
                state     <= fin ? IDLE : RUN;
                bus.busy  <= !fin;
                bus.count <= nxt;
                i         <= bus.ctrl == LOADY ? '0 : bus.ctrl == SHIFT ? i + 1'b1 : i;
                if (bus.ctrl == LOADZ) bus.result <= z;
            end
        end
    shift_add_datapath #(.W(W)) dp (
        .clk(clk),
        .rst_n(rst_n),
        .en(exec),
        .op(bus.ctrl),
        .val(bus.val),
        .z(z)
    );
endmodule

// File: tb/tb_microcode_exec.sv
// tb_microcode_exec: control-word memory model, table of multiply vectors, plus error/reset/back-to-back sequences.
module tb_microcode_exec;
    logic clk = 1'b0;
    logic rst_n;
    logic inject;
    logic [7:0] xop, yop;
    int checks = 0;
    int errors = 0;
    microcode_exec_if #(.W(8)) bus ();
    microcode_exec #(.W(8), .LAST_STEP(3'b100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Memory image: step n holds control word n; an injected illegal word replaces step 2.
    assign bus.ctrl = (inject && bus.count == 3'd2) ? 3'b111 : bus.count;
    assign bus.val  = bus.count == 3'd0 ? xop : yop;
    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] r;
    } vec_t;
    vec_t vecs[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask
    task automatic run(input logic [7:0] xa, input logic [7:0] ya, input logic [15:0] exp);
        int bc, dk;
        logic [15:0] prev;
        xop = xa;
        yop = ya;
        prev = bus.result;
        bc = 0;
        dk = 0;
        @(negedge clk) bus.start = 1'b1;
        for (int k = 1; k <= 40 && dk == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) bc++;
            if (k == 10) chk($sformatf("hold_%0dx%0d", xa, ya), 32'(bus.result), 32'(prev));
            if (bus.done) dk = k;
        end
        chk($sformatf("edges_%0dx%0d", xa, ya), dk, 19);
        chk($sformatf("busy_%0dx%0d", xa, ya), bc, 18);
        chk($sformatf("result_%0dx%0d", xa, ya), 32'(bus.result), 32'(exp));
        @(negedge clk);
        chk($sformatf("done_low_%0dx%0d", xa, ya), {bus.done, bus.busy, bus.count}, 0);
    endtask
    initial begin
        int ec, dc, ek, n, found;
        int dpos[3];
        logic [15:0] prev;
        vecs[0] = '{8'd3,   8'd5,   16'd15};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd7,   8'd0,   16'd0};
        vecs[3] = '{8'd0,   8'd9,   16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'd12,  8'd13,  16'd156};
        vecs[6] = '{8'd128, 8'd2,   16'd256};
        vecs[7] = '{8'd200, 8'd100, 16'd20000};
        rst_n = 1'b0;
        bus.start = 1'b0;
        inject = 1'b0;
        xop = '0;
        yop = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", 32'(bus.result), 0);
        chk("reset_flags", {bus.busy, bus.done, bus.err, bus.count}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_run", {bus.busy, bus.done, bus.count}, 0);
        for (int v = 0; v < 8; v++) run(vecs[v].x, vecs[v].y, vecs[v].r);
        // Illegal word at step 2: one err pulse, no done, result kept.
        prev = bus.result;
        inject = 1'b1;
        ec = 0; dc = 0; ek = 0;
        @(negedge clk) bus.start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.err) begin
                ec++;
                if (ek == 0) ek = k;
            end
            if (bus.done) dc++;
        end
        inject = 1'b0;
        chk("err_step", ek, 3);
        chk("err_pulses", ec, 1);
        chk("err_no_done", dc, 0);
        chk("err_result_kept", 32'(bus.result), 32'(prev));
        chk("err_idle", {bus.busy, bus.count}, 0);
        // Asynchronous reset in the middle of a run.
        xop = 8'd12;
        yop = 8'd13;
        found = 0;
        @(negedge clk) bus.start = 1'b1;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.count == 3'b011) found = 1;
        end
        chk("midrun_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_result", 32'(bus.result), 0);
        chk("midrun_reset_flags", {bus.busy, bus.done, bus.err, bus.count}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {bus.busy, bus.count}, 0);
        run(8'd3, 8'd5, 16'd15);
        // Start held high: back-to-back runs.
        xop = 8'd6;
        yop = 8'd7;
        n = 0;
        dpos = '{0, 0, 0};
        @(negedge clk) bus.start = 1'b1;
        for (int k = 1; k <= 80 && n < 3; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dpos[n] = k;
                n++;
                if (n == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("b2b_runs", n, 3);
        chk("b2b_first", dpos[0], 19);
        chk("b2b_gap1", dpos[1] - dpos[0], 19);
        chk("b2b_gap2", dpos[2] - dpos[1], 19);
        chk("b2b_result", 32'(bus.result), 42);
        repeat (2) @(negedge clk);
        chk("b2b_idle", {bus.busy, bus.done, bus.count}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/microcode_exec.md
MICROCODE_EXEC -- requirements
Module: microcode_exec

Interface
REQ-001 SHALL have parameter W, default 8, giving the operand width in bits.
REQ-002 SHALL have parameter LAST_STEP, default 3'b100, giving the step code that terminates a run.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, request to begin a run, sampled only in IDLE.
REQ-006 SHALL have port count, output, 3 bits, current step index driven to the control-word memory.
REQ-007 SHALL have port ctrl, input, 3 bits, control word returned combinationally by memory for count.
REQ-008 SHALL have port val, input, W bits, operand returned combinationally by memory for count.
REQ-009 SHALL have port busy, output, 1 bit, high while in RUN.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse when a run completes.
REQ-011 SHALL have port err, output, 1 bit, one-cycle pulse when an illegal control word is executed.
REQ-012 SHALL have port result, output, 2W bits, product Z latched at completion.

Function
REQ-013 SHALL implement FSM states IDLE and RUN: IDLE->RUN on start; RUN->IDLE after LOADZ executes or on an illegal code.
REQ-014 SHALL ignore start while in RUN; no queuing.
REQ-015 SHALL hold count at 3'b000 in IDLE; on entering RUN, count=3'b000.
REQ-016 SHALL execute ctrl 3'b000 (LOADX) as: X<=zero-extended val (2W bits), Y<=0, Z<=0, next count=3'b001.
REQ-017 SHALL execute ctrl 3'b001 (LOADY) as: Y<=val, X and Z held, iteration counter i<=0, next count=3'b010.
REQ-018 SHALL execute ctrl 3'b010 (ADD) as: if Y[0] then Z<=Z+X modulo 2^(2W), else Z held; next count=3'b011.
REQ-019 SHALL execute ctrl 3'b011 (SHIFT) as: Y<=Y>>1, X<=X<<1, i<=i+1; next count=3'b010 if i<W-1, else LAST_STEP.
REQ-020 SHALL execute ctrl 3'b100 (LOADZ) as: result<=Z, done=1 the following cycle, X and Y cleared, go IDLE.
REQ-021 SHALL treat ctrl 3'b101..3'b111 as illegal: pulse err one cycle, leave result unchanged, no done, go IDLE.
REQ-022 SHALL size i as clog2(W)+1 bits so that the count reaching W-1 never wraps.
REQ-023 SHALL make a run take exactly 2W+3 rising edges from the edge that samples start to the edge that sets done (19 for W=8).
REQ-024 SHALL hold result stable from done until the next completed run; a new run alone does not alter it.
REQ-025 SHALL allow start sampled high in the same cycle done is high to begin a new run (done is asserted only in IDLE).
REQ-026 SHALL register count, busy, done, err and result; no combinational path from start to any output.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-run, asynchronously force IDLE, count=0, busy=0, done=0, err=0, result=0, X=Y=Z=0, i=0.
REQ-028 SHALL, after rst_n deasserts, take no run until start is sampled high.

Structure
REQ-029 SHALL place the ctrl code constants (LOADX, LOADY, ADD, SHIFT, LOADZ) and the state enum in shared package microcode_pkg, also used by the memory block.
REQ-030 SHALL isolate the X/Y/Z registers and adder in one sub-module, shift_add_datapath; the FSM and step counter remain in microcode_exec.

Verification
REQ-031 Memory model with X=3, Y=5, W=8; pulse start -> done after 19 edges, result=15, busy high for 18 cycles.
REQ-032 Operands X=255, Y=255 -> result=65025, with no truncation in Z.
REQ-033 Y=0 -> every ADD holds Z; result=0; the done timing is identical to REQ-031.
REQ-034 Memory returns ctrl=3'b111 at step 2 -> err pulses once, done stays low, result retains its previous value, FSM returns to IDLE.
REQ-035 rst_n low at step 3'b011 mid-run -> all outputs zero immediately; a subsequent start gives a correct result of 15.
REQ-036 start held high continuously -> back-to-back runs, with each done exactly 19 edges after the sampling edge and start ignored while busy.
